// File: rtl/display_pkg.sv
// display_pkg: shared segment codes, FSM state type and BCD digit width.
//   SEG_BLANK  all segments off (active-low)
//   SEG_DASH   only segment g lit, shown on every digit when the value overflows
//   state_t    IDLE -> CONV -> LOAD
//   BCD_W      bits per BCD digit
package display_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam int         BCD_W     = 4;
    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;
endpackage

// File: rtl/bcd_dabble_seq.sv
// bcd_dabble_seq: sequential double-dabble, one value bit per cycle for DATA_W cycles.
//   clk, rst_n  clock, synchronous active-low reset (aborts a running conversion)
//   start       in   1                load value, clear BCD and ovf, begin converting
//   value       in   DATA_W           unsigned binary input
//   done        out  1                high in the cycle that performs the final shift
//   bcd_out     out  NUM_DISPLAYS*4   BCD result, digit i at [i*4+:4]
//   ovf         out  1                sticky: a 1 was shifted out of the top digit
module bcd_dabble_seq
    import display_pkg::*;
#(
    parameter int NUM_DISPLAYS = 6,
    parameter int DATA_W       = 20
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [DATA_W-1:0]           value,
    output logic                        done,
    output logic [NUM_DISPLAYS*BCD_W-1:0] bcd_out,
    output logic                        ovf
);
    localparam int BW = NUM_DISPLAYS * BCD_W;
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh;
    logic [BW-1:0]     adj;
    logic [CW-1:0]     cnt;
    logic              run;

    assign done = run && (cnt == CW'(DATA_W - 1));

    always_comb begin
        adj = bcd_out;
        for (int i = 0; i < NUM_DISPLAYS; i++)
            adj[i*BCD_W+:BCD_W] = (bcd_out[i*BCD_W+:BCD_W] >= 4'd5) ? bcd_out[i*BCD_W+:BCD_W] + 4'd3
                                                                     : bcd_out[i*BCD_W+:BCD_W];
    end

    // A digit beyond the register can only be nonzero if some 1 passes through the top bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh      <= '0;
            bcd_out <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            run     <= 1'b0;
        end else if (start) begin
            sh      <= value;
            bcd_out <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
            run     <= 1'b1;
        end else if (run) begin
            bcd_out <= {adj[BW-2:0], sh[DATA_W-1]};
            sh      <= sh << 1;
            ovf     <= ovf | adj[BW-1];
            cnt     <= cnt + 1'b1;
            run     <= !done;
        end
    end
endmodule

// File: rtl/display_decoder.sv
// display_decoder: BCD digit to active-low 7-segment pattern, bit order g..a.
//   digit  in   4  BCD digit; values 10..15 decode to blank
//   seg    out  7  segment pattern, 0 = segment lit
module display_decoder
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            4'd9: seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/display_value_ctrl.sv
// display_value_ctrl: handshake-fed binary value to multi-digit 7-segment display.
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     in   1               in_value is valid
//   in_ready     out  1               idle and able to accept a value
//   in_value     in   DATA_W          unsigned value to display
//   lz_blank     in   1               blank leading zeros, sampled at accept
//   blink_mask   in   NUM_DISPLAYS    per-digit blink enable (only with DISPLAY_BLINK_EN)
//   busy         out  1               conversion in progress
//   overflow     out  1               displayed value exceeded 10^NUM_DISPLAYS-1
//   display      out  NUM_DISPLAYS*7  active-low segments, digit i at [i*7+:7]
// Optional feature macro: DISPLAY_BLINK_EN (blink phase counter and blink_mask port).
module display_value_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DISPLAYS = 6,
    parameter int DATA_W       = 20,
    parameter int BLINK_DIV    = 25_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_value,
    input  logic                      lz_blank,
`ifdef DISPLAY_BLINK_EN
    input  logic [NUM_DISPLAYS-1:0]   blink_mask,
`endif
    output logic                      busy,
    output logic                      overflow,
    output logic [NUM_DISPLAYS*7-1:0] display
);
    state_t                          state;
    logic                            lz_q;
    logic                            done;
    logic                            ovf;
    logic [NUM_DISPLAYS*BCD_W-1:0]   bcd;
    logic [NUM_DISPLAYS*7-1:0]       seg_dec;
    logic [NUM_DISPLAYS*7-1:0]       disp_next;
    logic [NUM_DISPLAYS*7-1:0]       disp_q;

    wire accept = in_valid && in_ready;

    assign in_ready = rst_n && (state == IDLE);
    assign busy     = (state != IDLE);

    bcd_dabble_seq #(.NUM_DISPLAYS(NUM_DISPLAYS), .DATA_W(DATA_W)) u_dabble (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept),
        .value   (in_value),
        .done    (done),
        .bcd_out (bcd),
        .ovf     (ovf)
    );

    for (genvar g = 0; g < NUM_DISPLAYS; g++) begin : g_dec
        display_decoder u_dec (.digit(bcd[g*BCD_W+:BCD_W]), .seg(seg_dec[g*7+:7]));
    end

    // Scanning from the top digit, a digit is shown once any digit at or above it is nonzero;
    // digit 0 is always shown so a zero value still displays '0'.
    always_comb begin
        logic shown;
        shown     = 1'b0;
        disp_next = '0;
        for (int i = NUM_DISPLAYS - 1; i >= 0; i--) begin
            shown = shown || (bcd[i*BCD_W+:BCD_W] != 4'd0) || (i == 0);
            disp_next[i*7+:7] = ovf ? SEG_DASH : (lz_q && !shown) ? SEG_BLANK : seg_dec[i*7+:7];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lz_q     <= 1'b0;
            disp_q   <= {NUM_DISPLAYS{SEG_BLANK}};
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= CONV;
                    lz_q  <= lz_blank;
                end
                CONV: if (done) state <= LOAD;
                LOAD: begin
                    state    <= IDLE;
                    disp_q   <= disp_next;
                    overflow <= ovf;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DISPLAY_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [CW-1:0]             blink_cnt;
    logic                      phase_on;
    logic [NUM_DISPLAYS*7-1:0] disp_out;

    wire wrap = (blink_cnt == CW'(BLINK_DIV - 1));

    // Blanking sits after the load register, so mask/phase changes show one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
            disp_out  <= {NUM_DISPLAYS{SEG_BLANK}};
        end else begin
            blink_cnt <= wrap ? '0 : blink_cnt + 1'b1;
            phase_on  <= wrap ? !phase_on : phase_on;
            for (int i = 0; i < NUM_DISPLAYS; i++)
                disp_out[i*7+:7] <= (!phase_on && blink_mask[i]) ? SEG_BLANK : disp_q[i*7+:7];
        end
    end

    assign display = disp_out;
`else
    assign display = disp_q;
`endif
endmodule

// File: tb/tb_display_value_ctrl.sv
// tb_display_value_ctrl: directed self-checking bench for display_value_ctrl (default build).
module tb_display_value_ctrl;
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, S9 = 7'h10;
    localparam logic [6:0] B  = 7'h7F, D = 7'h3F;
    localparam logic [41:0] ALL_BLANK = {B, B, B, B, B, B};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_value = '0;
    logic        lz_blank = 1'b0;
    logic        busy;
    logic        overflow;
    logic [41:0] display;

    int          errors = 0;
    int          checks = 0;
    logic [41:0] exp_last;

    display_value_ctrl #(.NUM_DISPLAYS(6), .DATA_W(20), .BLINK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .lz_blank (lz_blank),
        .busy     (busy),
        .overflow (overflow),
        .display  (display)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [19:0] v, input logic lz, input logic [41:0] exp_disp,
                        input logic exp_ovf);
        int n;
        in_valid = 1'b1;
        in_value = v;
        lz_blank = lz;
        step();
        in_valid = 1'b0;
        chk("busy_conv", 64'(busy), 64'(1));
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
            if (n == 20) chk("hold_prev", 64'(display), 64'(exp_last));
        end
        chk("ready_low_cycles", 64'(n), 64'(21));
        step();
        chk("display", 64'(display), 64'(exp_disp));
        chk("overflow", 64'(overflow), 64'(exp_ovf));
        exp_last = exp_disp;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_display", 64'(display), 64'(ALL_BLANK));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        step();
        chk("ready_after_release", 64'(in_ready), 64'(1));
        exp_last = ALL_BLANK;

        send(20'd123456, 1'b0, {S1, S2, S3, S4, S5, S6}, 1'b0);
        send(20'd42, 1'b1, {B, B, B, B, S4, S2}, 1'b0);
        send(20'd0, 1'b1, {B, B, B, B, B, S0}, 1'b0);
        send(20'd999999, 1'b1, {S9, S9, S9, S9, S9, S9}, 1'b0);
        send(20'd1000000, 1'b1, {D, D, D, D, D, D}, 1'b1);
        send(20'd7, 1'b0, {S0, S0, S0, S0, S0, S7}, 1'b0);

        // in_valid held with a different value during CONV must be ignored
        in_valid = 1'b1;
        in_value = 20'd555;
        lz_blank = 1'b0;
        step();
        in_value = 20'd777;
        repeat (19) step();
        chk("bp_still_busy", 64'(busy), 64'(1));
        in_valid = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("bp_ready_low_cycles", 64'(n), 64'(2));
        step();
        chk("bp_display", 64'(display), 64'({S0, S0, S0, S5, S5, S5}));
        chk("bp_no_second_accept", 64'(busy), 64'(0));

        // reset in the middle of a conversion: no load, outputs return to reset values
        in_valid = 1'b1;
        in_value = 20'd123456;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        chk("abort_display", 64'(display), 64'(ALL_BLANK));
        chk("abort_ready", 64'(in_ready), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
        repeat (25) step();
        chk("abort_no_load", 64'(display), 64'(ALL_BLANK));
        chk("abort_overflow", 64'(overflow), 64'(0));
        chk("abort_ready_again", 64'(in_ready), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
